// File: rtl/num_entry.sv
// Keypad decimal entry: digits accumulate into a binary value; backspace, clear and enter are supported.
// Most keys take effect in one cycle; backspace runs a WIDTH-cycle bit-serial divide-by-10 while busy is high.
module num_entry #(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] cur_num,
    output logic [3:0]       digit_cnt,
    output logic [WIDTH-1:0] out_num,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [3:0]    MAX_CNT  = 4'(MAX_DIGITS);
    localparam logic [3:0]    KEY_BS   = 4'd10;
    localparam logic [3:0]    KEY_CLR  = 4'd11;
    localparam logic [3:0]    KEY_ENT  = 4'd12;

    typedef enum logic {ENTRY, DIV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out MSB-first, quotient shifts in at LSB
    logic [4:0]       rem_q, rem_d;
    logic [CW-1:0]    bit_q, bit_d;

    logic [5:0]       trial;
    logic             ge10;
    logic [4:0]       rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] times10;

    always_comb begin
        trial   = {rem_q, dvd_q[WIDTH-1]};
        ge10    = (trial >= 6'd10);
        rem_nx  = ge10 ? 5'(trial - 6'd10) : trial[4:0];
        quo_nx  = {dvd_q[WIDTH-2:0], ge10};
        times10 = (cur_q << 3) + (cur_q << 1) + WIDTH'(key_code);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        case (state_q)
            ENTRY: begin
                if (key_valid) begin
                    if (key_code <= 4'd9) begin
                        if (cnt_q == MAX_CNT) begin
                            err_d = 1'b1;
                        end else if (cur_q == '0) begin
                            // leading zeros leave the value and count untouched
                            if (key_code != 4'd0) begin
                                cur_d = WIDTH'(key_code);
                                cnt_d = 4'd1;
                            end
                        end else begin
                            cur_d = times10;
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (key_code == KEY_BS) begin
                        if (cnt_q != 4'd0) begin
                            dvd_d   = cur_q;
                            rem_d   = '0;
                            bit_d   = '0;
                            state_d = DIV;
                        end
                    end else if (key_code == KEY_CLR) begin
                        cur_d = '0;
                        cnt_d = 4'd0;
                    end else if (key_code == KEY_ENT) begin
                        out_d  = cur_q;
                        cur_d  = '0;
                        cnt_d  = 4'd0;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DIV: begin
                if (key_valid && key_code == KEY_CLR) begin
                    cur_d   = '0;
                    cnt_d   = 4'd0;
                    state_d = ENTRY;
                end else begin
                    err_d = key_valid;
                    dvd_d = quo_nx;
                    rem_d = rem_nx;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        cur_d   = quo_nx;
                        cnt_d   = cnt_q - 4'd1;
                        state_d = ENTRY;
                    end
                end
            end
            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ENTRY;
            cur_q   <= '0;
            out_q   <= '0;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dvd_q   <= '0;
            rem_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
        end
    end

    assign cur_num   = cur_q;
    assign digit_cnt = cnt_q;
    assign out_num   = out_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q == DIV);

endmodule

// File: doc/num_entry.md
Name: num_entry

Overview:
- Keypad-style decimal entry block: accumulates decimal digit keystrokes into a binary value.
- Supports backspace, clear and enter; on enter, commits the value to a registered binary output.
- Inverse path of the binary-to-decimal display chain: the in-progress value (cur_num) feeds the six-digit seven-segment display, so MAX_DIGITS is capped at 6 by default.
- Backspace uses a bit-serial restoring divide-by-10, so no combinational divider is needed.

Parameters:
- WIDTH, 32, width of cur_num, out_num and the internal divider datapath.
- MAX_DIGITS, 6, maximum significant decimal digits accepted; must satisfy 10^MAX_DIGITS - 1 < 2^WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- key_valid  input  1  one-cycle strobe; key_code is sampled on the same edge.
- key_code  input  4  0-9 = digit, 10 = backspace, 11 = clear, 12 = enter, 13-15 = invalid.
- cur_num  output  WIDTH  value currently being entered (drives the display).
- digit_cnt  output  4  number of significant digits in cur_num.
- out_num  output  WIDTH  last committed value.
- done  output  1  one-cycle pulse, high the cycle after enter is accepted.
- busy  output  1  high while a backspace division is running.
- err  output  1  one-cycle pulse, high the cycle after a rejected key.

Behaviour:
- Reset (async, resetn=0): cur_num=0, digit_cnt=0, out_num=0, done=0, busy=0, err=0, state=ENTRY, divider registers cleared. Reset mid-division aborts it with no partial update.
- States:
  - ENTRY: idle, keys accepted.
  - DIV: restoring division of cur_num by 10 in progress.
- done and err default to 0 every cycle; they are set only for the single cycle after the triggering edge.
- ENTRY, key_valid=1, digit d:
  - digit_cnt < MAX_DIGITS and cur_num != 0: cur_num <= cur_num*10 + d (shift-add, (x<<3)+(x<<1)+d, WIDTH bits), digit_cnt++.
  - cur_num == 0 and d == 0: no change, no err (leading zeros suppressed).
  - cur_num == 0 and d != 0: cur_num <= d, digit_cnt <= 1.
  - digit_cnt == MAX_DIGITS: key ignored, err pulse.
- ENTRY, backspace:
  - digit_cnt == 0: ignored, no err.
  - Otherwise: latch dividend = cur_num, go to DIV, busy=1 from the next cycle.
- DIV: one quotient bit per clock, MSB first. The remainder register is 5 bits: compare with 10, subtract and set the quotient bit.
  - After exactly WIDTH cycles in DIV: cur_num <= quotient, digit_cnt--, busy <= 0, state <= ENTRY.
  - busy is high for exactly WIDTH cycles; cur_num is unchanged until the final edge.
- ENTRY, clear: cur_num <= 0, digit_cnt <= 0, out_num unchanged.
- ENTRY, enter: out_num <= cur_num, cur_num <= 0, digit_cnt <= 0, done pulse. Enter with digit_cnt == 0 commits 0 and still pulses done.
- ENTRY, codes 13-15: ignored, err pulse.
- DIV, clear: aborts the division immediately. cur_num <= 0, digit_cnt <= 0, busy <= 0, state <= ENTRY, no err.
- DIV, any other key (digit, backspace, enter, invalid): ignored, err pulse, division continues.
- Key arriving on the final DIV edge: treated as arriving in DIV (rejected with err, except clear, which wins over the quotient write).
- Back-to-back key_valid on consecutive cycles in ENTRY: each is processed independently, one per cycle.
- No arithmetic overflow is possible, because MAX_DIGITS bounds cur_num.

Test Plan:
- Keys 1,2,3 then enter -> cur_num 1, 12, 123 with digit_cnt 3; then out_num=123, done high exactly one cycle, cur_num=0, digit_cnt=0.
- Keys 0,0,7 -> cur_num=7, digit_cnt=1, err never asserted.
- Key 9 seven times -> cur_num=999999, digit_cnt=6; 7th key gives an err pulse and cur_num stays 999999.
- Keys 4,5,6,7 then backspace -> busy high exactly 32 cycles, then cur_num=456, digit_cnt=3. A digit 8 sent mid-busy gives an err pulse and the result is still 456.
- Keys 8,1 then backspace, then clear 5 cycles later -> busy drops the next cycle, cur_num=0, digit_cnt=0, out_num unchanged.
- Keys 5,5, backspace, resetn pulsed low mid-DIV -> all outputs 0 asynchronously; key 3 afterwards gives cur_num=3.
